// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port instruction/data memory bus between the fetch stage
// and the load/store path. A four-state FSM (IDLE, IF_BUSY, DM_BUSY, DONE)
// serialises requests onto a req/ack bus and returns read data to the owner.
// Data has priority. After DATA_BURST consecutive data grants with fetch
// waiting, the next grant goes to fetch so that fetch always makes progress.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When this macro is defined, a BUSY phase with no bus_ack for TIMEOUT cycles
//   is ended by the block. It returns rdata = 0, gives the valid pulse and
//   pulses bus_err. When the macro is not defined, BUSY waits forever and
//   bus_err is tied to 0.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (level) and address
//   if_rdata/if_valid               fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   load/store request (level)
//   dm_rdata/dm_valid               load data, one-cycle completion pulse
//   bus_req/bus_we/bus_addr/
//   bus_wdata                       memory bus request (held until bus_ack)
//   bus_rdata/bus_ack               memory read data and one-cycle completion
//   bus_err                         one-cycle pulse on timeout termination
//   stall                           combinational stall to the hazard logic
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned DATA_BURST = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic        stall
);

   if (DATA_BURST == 0 || DATA_BURST > 7 || TIMEOUT == 0) begin : g_param_check
      $error("mem_port_arbiter: DATA_BURST must be 1..7 and TIMEOUT nonzero");
   end

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;

   localparam logic [2:0] BURST_MAX = 3'(DATA_BURST);

   state_t      state_q, state_d;
   logic [2:0]  burst_cnt_q, burst_cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        if_valid_q, if_valid_d;
   logic        dm_valid_q, dm_valid_d;
   logic        grant_dm;

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             bus_err_q, bus_err_d;
`endif

   // Fetch takes the bus from a pending data request only after the burst budget is used up.
   assign grant_dm = dm_req & (~if_req | (burst_cnt_q != BURST_MAX));

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      bus_err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_dm) begin
               state_d     = DM_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = dm_we;
               bus_addr_d  = dm_addr;
               bus_wdata_d = dm_wdata;
               if (!if_req)                     burst_cnt_d = 3'd0;
               else if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end else if (if_req) begin
               state_d     = IF_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr;
               bus_wdata_d = 32'd0;
               burst_cnt_d = 3'd0;
`ifdef ARB_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (bus_ack) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               if (state_q == IF_BUSY) begin
                  if_rdata_d = bus_rdata;
                  if_valid_d = 1'b1;
               end else begin
                  dm_valid_d = 1'b1;
                  // A store leaves the load-data register unchanged.
                  if (!bus_we_q) dm_rdata_d = bus_rdata;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               // This is the TIMEOUT-th cycle with no ack. End the transaction with zero data.
               state_d   = DONE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (state_q == IF_BUSY) begin
                  if_rdata_d = 32'd0;
                  if_valid_d = 1'b1;
               end else begin
                  dm_rdata_d = 32'd0;
                  dm_valid_d = 1'b1;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         burst_cnt_q <= 3'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_valid  = if_valid_q;
   assign dm_valid  = dm_valid_q;
`ifdef ARB_TIMEOUT_EN
   assign bus_err   = bus_err_q;
`else
   assign bus_err   = 1'b0;
`endif

   // stall drops in the cycle the matching valid is high.
   assign stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter (DATA_BURST = 3, TIMEOUT = 15).
// The stimulus runs as a linear sequence of steps in a single initial block.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so they always show the state left by the previous edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;
   logic        stall;

   int vectors = 0;
   int errors  = 0;

   mem_port_arbiter #(.DATA_BURST(3), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin : stim
      string       kinds;
      int          dn;
      logic [31:0] exp_addr;

      rst_n     = 1'b0;
      if_req    = 1'b0;
      if_addr   = 32'd0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = 32'd0;
      dm_wdata  = 32'd0;
      bus_rdata = 32'd0;
      bus_ack   = 1'b0;
      tick();
      tick();

      // ---- reset state
      check("rst bus_req",  bus_req,  0);
      check("rst bus_we",   bus_we,   0);
      check("rst bus_addr", bus_addr, 0);
      check("rst bus_wdata", bus_wdata, 0);
      check("rst if_valid", if_valid, 0);
      check("rst dm_valid", dm_valid, 0);
      check("rst if_rdata", if_rdata, 0);
      check("rst dm_rdata", dm_rdata, 0);
      check("rst bus_err",  bus_err,  0);
      check("rst stall",    stall,    0);
      rst_n = 1'b1;
      tick();

      // ---- single fetch, ack one cycle after the grant
      if_req  = 1'b1;
      if_addr = 32'h100;
      #1;
      check("f1 stall at request", stall, 1);
      tick();
      check("f1 bus_req",  bus_req,  1);
      check("f1 bus_addr", bus_addr, 32'h100);
      check("f1 bus_we",   bus_we,   0);
      check("f1 stall busy", stall,  1);
      check("f1 if_valid early", if_valid, 0);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0050_0093;
      tick();
      bus_ack = 1'b0;
      check("f1 if_valid", if_valid, 1);
      check("f1 if_rdata", if_rdata, 32'h0050_0093);
      check("f1 bus_req drop", bus_req, 0);
      check("f1 stall at valid", stall, 0);
      if_req = 1'b0;
      tick();
      check("f1 if_valid single", if_valid, 0);

      // ---- bus_ack while IDLE is ignored
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0;
      check("idle ack if_valid", if_valid, 0);
      check("idle ack dm_valid", dm_valid, 0);
      check("idle ack if_rdata", if_rdata, 32'h0050_0093);
      check("idle ack bus_req",  bus_req,  0);

      // ---- simultaneous fetch and load: data first, then fetch
      if_req  = 1'b1;
      if_addr = 32'h104;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h2000;
      tick();
      check("both grant data addr", bus_addr, 32'h2000);
      check("both grant data we",   bus_we,   0);
      bus_ack   = 1'b1;
      bus_rdata = 32'h1111_2222;
      tick();
      bus_ack = 1'b0;
      check("both dm_valid", dm_valid, 1);
      check("both dm_rdata", dm_rdata, 32'h1111_2222);
      check("both if_valid idle", if_valid, 0);
      check("both stall fetch pending", stall, 1);
      dm_req = 1'b0;
      tick();
      check("both DONE->IDLE no grant", bus_req, 0);
      tick();
      check("both fetch grant req",  bus_req,  1);
      check("both fetch grant addr", bus_addr, 32'h104);
      bus_ack   = 1'b1;
      bus_rdata = 32'h2222_3333;
      tick();
      bus_ack = 1'b0;
      check("both if_valid",  if_valid, 1);
      check("both if_rdata",  if_rdata, 32'h2222_3333);
      check("both dm_rdata hold", dm_rdata, 32'h1111_2222);
      if_req = 1'b0;
      tick();

      // ---- store with four wait cycles
      dm_req    = 1'b1;
      dm_we     = 1'b1;
      dm_addr   = 32'h2004;
      dm_wdata  = 32'hDEAD_BEEF;
      bus_rdata = 32'hBADB_AD00;
      tick();
      check("st bus_req",  bus_req,  1);
      check("st bus_we",   bus_we,   1);
      check("st bus_addr", bus_addr, 32'h2004);
      for (int w = 0; w < 4; w++) begin
         tick();
         check("st wait bus_req",   bus_req,   1);
         check("st wait bus_we",    bus_we,    1);
         check("st wait bus_wdata", bus_wdata, 32'hDEAD_BEEF);
         check("st wait dm_valid",  dm_valid,  0);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      check("st dm_valid", dm_valid, 1);
      check("st dm_rdata unchanged", dm_rdata, 32'h1111_2222);
      dm_req = 1'b0;
      dm_we  = 1'b0;
      tick();

      // ---- burst limit: fetch held, five loads -> D D D F D D
      kinds   = "DDDFDD";
      dn      = 0;
      if_req  = 1'b1;
      if_addr = 32'h300;
      dm_req  = 1'b1;
      dm_addr = 32'h3000;
      for (int g = 0; g < 6; g++) begin
         tick();
         exp_addr = (kinds[g] == "D") ? 32'h3000 + 32'(4 * dn) : 32'h300;
         check("burst grant addr", bus_addr, exp_addr);
         check("burst grant req",  bus_req,  1);
         bus_ack   = 1'b1;
         bus_rdata = exp_addr ^ 32'h5A5A_0000;
         tick();
         bus_ack = 1'b0;
         if (kinds[g] == "D") begin
            check("burst dm_valid", dm_valid, 1);
            check("burst dm_rdata", dm_rdata, exp_addr ^ 32'h5A5A_0000);
            dn++;
            if (dn == 5) dm_req = 1'b0;
            else         dm_addr = 32'h3000 + 32'(4 * dn);
         end else begin
            check("burst if_valid", if_valid, 1);
            check("burst if_rdata", if_rdata, 32'h300 ^ 32'h5A5A_0000);
            if_addr = 32'h304;
         end
         if (g == 5) if_req = 1'b0;
         tick();
      end

      // ---- bus never acks
      dm_req    = 1'b1;
      dm_we     = 1'b0;
      dm_addr   = 32'h4000;
      bus_rdata = 32'hFFFF_FFFF;
      tick();
      check("tmo grant req", bus_req, 1);
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 14; c++) begin
         tick();
         check("tmo wait bus_req",  bus_req,  1);
         check("tmo wait dm_valid", dm_valid, 0);
         check("tmo wait bus_err",  bus_err,  0);
      end
      tick();
      check("tmo dm_valid", dm_valid, 1);
      check("tmo bus_err",  bus_err,  1);
      check("tmo dm_rdata", dm_rdata, 0);
      check("tmo bus_req",  bus_req,  0);
      dm_req = 1'b0;
      tick();
      check("tmo bus_err single", bus_err, 0);
`else
      for (int c = 0; c < 20; c++) begin
         tick();
         check("hang bus_req",  bus_req,  1);
         check("hang dm_valid", dm_valid, 0);
         check("hang bus_err",  bus_err,  0);
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h4444_5555;
      tick();
      bus_ack = 1'b0;
      check("hang dm_valid", dm_valid, 1);
      check("hang dm_rdata", dm_rdata, 32'h4444_5555);
      dm_req = 1'b0;
      tick();
`endif
      tick();

      // ---- reset in the middle of BUSY
      if_req  = 1'b1;
      if_addr = 32'h500;
      tick();
      check("mid-rst grant", bus_req, 1);
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      check("mid-rst bus_req async", bus_req,  0);
      check("mid-rst if_rdata",      if_rdata, 0);
      bus_ack   = 1'b1;
      bus_rdata = 32'h7777_7777;
      tick();
      check("mid-rst if_valid a", if_valid, 0);
      check("mid-rst stall",      stall,    1);
      tick();
      check("mid-rst if_valid b", if_valid, 0);
      bus_ack = 1'b0;
      rst_n   = 1'b1;
      if_addr = 32'h600;
      tick();
      check("post-rst grant req",  bus_req,  1);
      check("post-rst grant addr", bus_addr, 32'h600);
      bus_ack   = 1'b1;
      bus_rdata = 32'h6666_7777;
      tick();
      bus_ack = 1'b0;
      check("post-rst if_valid", if_valid, 1);
      check("post-rst if_rdata", if_rdata, 32'h6666_7777);
      if_req = 1'b0;
      tick();
      check("post-rst idle", bus_req, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
